// File: rtl/bus_pkg.sv
// Shared bus definitions: slave FSM states, slave memory sizes and wait-state defaults.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } slave_state_t;

    localparam int SLAVE0_SIZE         = 4096;
    localparam int SLAVE1_SIZE         = 4096;
    localparam int SLAVE2_SIZE         = 2048;
    localparam int DEFAULT_WAIT_STATES = 2;

    // Wide enough for the largest wait-state setting (15).
    localparam int WAIT_CNT_W = 4;

    // Index width of a memory of the given depth; never narrower than one bit.
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/slave_mem_array.sv
// Single-port byte RAM: synchronous write, asynchronous read, no reset on contents.
module slave_mem_array
    import bus_pkg::*;
#(
    parameter int DEPTH      = 4096,
    parameter int DATA_WIDTH = 8,
    parameter int IDX_W      = idx_width(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [IDX_W-1:0]      addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem[addr_i];

endmodule

// File: rtl/bus_slave_mem.sv
// Memory-backed bus responder with programmable wait states and out-of-range error.
// Optional write protection (wprot_i) is built when BUS_SLAVE_WPROT_EN is defined.
module bus_slave_mem
    import bus_pkg::*;
#(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 8,
    parameter int MEM_DEPTH   = 4096,
    parameter int WAIT_STATES = DEFAULT_WAIT_STATES
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  valid_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  we_i,
`ifdef BUS_SLAVE_WPROT_EN
    input  logic                  wprot_i,
`endif
    output logic                  ready_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  err_o
);

    localparam int IDX_W = idx_width(MEM_DEPTH);
    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(MEM_DEPTH);
    localparam logic [WAIT_CNT_W-1:0] CNT_LOAD =
        (WAIT_STATES > 0) ? WAIT_CNT_W'(WAIT_STATES - 1) : '0;

    slave_state_t state_reg, state_next;
    logic [WAIT_CNT_W-1:0] cnt_reg, cnt_next;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [DATA_WIDTH-1:0] wdata_reg;
    logic                  we_reg;
    logic                  ready_reg, ready_next;
    logic                  err_reg, err_next;
    logic [DATA_WIDTH-1:0] rdata_reg, rdata_next;

    logic                  accept;
    logic                  resp_enter;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [DATA_WIDTH-1:0] cur_wdata;
    logic                  cur_we;
    logic                  cur_prot;
    logic                  cur_oor;
    logic                  cur_err;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // In IDLE the request is taken straight from the inputs so that a
    // zero-wait or error access can complete on the accepting edge.
    assign cur_addr  = (state_reg == IDLE) ? addr_i  : addr_reg;
    assign cur_wdata = (state_reg == IDLE) ? wdata_i : wdata_reg;
    assign cur_we    = (state_reg == IDLE) ? we_i    : we_reg;

`ifdef BUS_SLAVE_WPROT_EN
    logic prot_reg;

    assign cur_prot = (state_reg == IDLE) ? wprot_i : prot_reg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prot_reg <= 1'b0;
        end else if (accept) begin
            prot_reg <= wprot_i;
        end
    end
`else
    assign cur_prot = 1'b0;
`endif

    assign cur_oor = ({1'b0, cur_addr} >= DEPTH_LIM);
    assign cur_err = cur_oor | (cur_we & cur_prot);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        accept     = 1'b0;
        resp_enter = 1'b0;
        case (state_reg)
            IDLE: begin
                if (valid_i) begin
                    accept = 1'b1;
                    // Out-of-range accesses bypass the wait states entirely.
                    if (cur_oor || (WAIT_STATES == 0)) begin
                        state_next = RESP;
                        resp_enter = 1'b1;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (!valid_i) begin
                    state_next = IDLE;
                end else if (cnt_reg == '0) begin
                    state_next = RESP;
                    resp_enter = 1'b1;
                end else begin
                    cnt_next = cnt_reg - WAIT_CNT_W'(1);
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        ready_next = 1'b0;
        err_next   = 1'b0;
        rdata_next = '0;
        mem_we     = 1'b0;
        if (resp_enter) begin
            ready_next = 1'b1;
            err_next   = cur_err;
            mem_we     = cur_we & ~cur_err;
            if (!cur_we && !cur_err) begin
                rdata_next = mem_rdata;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            we_reg    <= 1'b0;
            ready_reg <= 1'b0;
            err_reg   <= 1'b0;
            rdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            ready_reg <= ready_next;
            err_reg   <= err_next;
            rdata_reg <= rdata_next;
            if (accept) begin
                addr_reg  <= addr_i;
                wdata_reg <= wdata_i;
                we_reg    <= we_i;
            end
        end
    end

    // The RAM has no reset, so its write strobe must be blocked while reset is held.
    slave_mem_array #(
        .DEPTH      (MEM_DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_W      (IDX_W)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (mem_we & rst_ni),
        .addr_i  (cur_addr[IDX_W-1:0]),
        .wdata_i (cur_wdata),
        .rdata_o (mem_rdata)
    );

    assign ready_o = ready_reg;
    assign err_o   = err_reg;
    assign rdata_o = rdata_reg;

endmodule
